// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share a single ALU through a round-robin arbiter.
// The result goes into a one-deep output register (EMPTY/FULL) with a
// valid/ready handshake. When the consumer takes the held result, a new
// operation can load in the same cycle, so there is no bubble.
// op_count counts the results the consumer has taken.

// Shared ALU: add, sub (A-B), and, xor, plus carry-out and signed overflow.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] out,
  output logic             Cout,
  output logic             OF
);

  logic [WIDTH:0] wide_s;

  // Compute the result and flags for the selected opcode.
  // For sub, Cout is the carry out of A + ~B + 1, so Cout=1 means no borrow.
  always_comb begin
    wide_s = {(WIDTH+1){1'b0}};
    out    = {WIDTH{1'b0}};
    Cout   = 1'b0;
    OF     = 1'b0;
    case (control)
      2'd0: begin
        wide_s = {1'b0, A} + {1'b0, B};
        out    = wide_s[WIDTH-1:0];
        Cout   = wide_s[WIDTH];
        OF     = (A[WIDTH-1] == B[WIDTH-1]) && (wide_s[WIDTH-1] != A[WIDTH-1]);
      end
      2'd1: begin
        wide_s = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        out    = wide_s[WIDTH-1:0];
        Cout   = wide_s[WIDTH];
        OF     = (A[WIDTH-1] != B[WIDTH-1]) && (wide_s[WIDTH-1] != A[WIDTH-1]);
      end
      2'd2: begin
        out = A & B;
      end
      2'd3: begin
        out = A ^ B;
      end
      default: begin
        out = {WIDTH{1'b0}};
      end
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             res_cout,
  output logic             res_of,
  output logic             res_zf,
  output logic             res_sf,
  output logic             res_id,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [WIDTH-1:0] res_out_q, res_out_d;
  logic             res_cout_q, res_cout_d;
  logic             res_of_q, res_of_d;
  logic             res_zf_q, res_zf_d;
  logic             res_sf_q, res_sf_d;
  logic             res_id_q, res_id_d;

  logic             can_accept_s;
  logic             winner_s;
  logic             grant_s;
  logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_out_s;
  logic [1:0]       alu_op_s;
  logic             alu_cout_s, alu_of_s;

  // Arbitration: pick the winner, raise its ready, and steer its operands to the ALU.
  // The grant is also gated by rst_n, so no transfer happens while reset is low.
  always_comb begin
    can_accept_s = (state_q == ST_FULL) ? res_ready : 1'b1;
    if (req0_valid && req1_valid) begin
      winner_s = prio_q;
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    grant_s    = rst_n && can_accept_s && (req0_valid || req1_valid);
    req0_ready = grant_s && !winner_s;
    req1_ready = grant_s && winner_s;
    if (grant_s && winner_s) begin
      alu_a_s  = req1_A;
      alu_b_s  = req1_B;
      alu_op_s = req1_op;
    end else begin
      alu_a_s  = req0_A;
      alu_b_s  = req0_B;
      alu_op_s = req0_op;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .A       (alu_a_s),
    .B       (alu_b_s),
    .control (alu_op_s),
    .out     (alu_out_s),
    .Cout    (alu_cout_s),
    .OF      (alu_of_s)
  );

  // Output stage next state: load on grant, drain on consume, else hold.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    op_count_d = op_count_q;
    res_out_d  = res_out_q;
    res_cout_d = res_cout_q;
    res_of_d   = res_of_q;
    res_zf_d   = res_zf_q;
    res_sf_d   = res_sf_q;
    res_id_d   = res_id_q;
    if ((state_q == ST_FULL) && res_ready) begin
      op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      op_count_d = op_count_q;
    end
    if (grant_s) begin
      state_d    = ST_FULL;
      prio_d     = !winner_s;
      res_out_d  = alu_out_s;
      res_cout_d = alu_cout_s;
      res_of_d   = alu_of_s;
      res_zf_d   = (alu_out_s == {WIDTH{1'b0}});
      res_sf_d   = alu_out_s[WIDTH-1];
      res_id_d   = winner_s;
    end else if ((state_q == ST_FULL) && res_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      prio_q     <= 1'b0;
      op_count_q <= {CNT_W{1'b0}};
      res_out_q  <= {WIDTH{1'b0}};
      res_cout_q <= 1'b0;
      res_of_q   <= 1'b0;
      res_zf_q   <= 1'b0;
      res_sf_q   <= 1'b0;
      res_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      op_count_q <= op_count_d;
      res_out_q  <= res_out_d;
      res_cout_q <= res_cout_d;
      res_of_q   <= res_of_d;
      res_zf_q   <= res_zf_d;
      res_sf_q   <= res_sf_d;
      res_id_q   <= res_id_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_out   = res_out_q;
  assign res_cout  = res_cout_q;
  assign res_of    = res_of_q;
  assign res_zf    = res_zf_q;
  assign res_sf    = res_sf_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; SHALL match the shared ALU instance width.
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle (valid&ready = transfer).
REQ-007 req0_A, req0_B  input  WIDTH each  requester 0 signed operands.
REQ-008 req0_op  input  2  requester 0 opcode: 0 add, 1 sub (A-B), 2 and, 3 xor.
REQ-009 req1_valid, req1_ready, req1_A, req1_B, req1_op  as REQ-005..REQ-008 for requester 1.
REQ-010 res_valid  output  1  result register holds an unconsumed result.
REQ-011 res_ready  input  1  consumer accepts result this cycle.
REQ-012 res_out  output  WIDTH  registered ALU out.
REQ-013 res_cout, res_of  output  1 each  registered ALU Cout and OF.
REQ-014 res_zf, res_sf  output  1 each  registered zero flag (res_out==0) and sign flag (res_out[WIDTH-1]).
REQ-015 res_id  output  1  requester index that issued the held result.
REQ-016 op_count  output  CNT_W  count of results consumed by the downstream.

Function
REQ-017 Block SHALL instantiate exactly one ALU (ports out, Cout, A, B, control, OF) and share it between both requesters.
REQ-018 ALU A/B/control SHALL be driven combinationally from the granted requester's fields; from requester 0 when no grant.
REQ-019 Output stage SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-020 can_accept = EMPTY, or FULL with res_ready=1 (same-cycle replace, no bubble).
REQ-021 Grant SHALL occur only when can_accept=1 and at least one reqN_valid=1; at most one reqN_ready high per cycle.
REQ-022 reqN_ready SHALL be combinational, asserted only for the granted requester, and never when its reqN_valid=0.
REQ-023 Arbitration round-robin: 1-bit pointer prio; both valid -> requester prio wins; one valid -> that one wins.
REQ-024 prio SHALL toggle to the non-winner after every grant; unchanged when no grant.
REQ-025 On grant, next edge SHALL load res_out/res_cout/res_of/res_zf/res_sf from ALU outputs, res_id with winner index, and set FULL.
REQ-026 Latency: operation accepted at edge N SHALL present res_valid=1 with its result immediately after edge N (one cycle).
REQ-027 FULL with res_ready=1 and no grant -> EMPTY; FULL with res_ready=0 -> all res_* held stable.
REQ-028 Result fields SHALL not change while res_valid=1 and res_ready=0.
REQ-029 op_count SHALL increment on each res_valid&res_ready cycle and wrap from 2^CNT_W-1 to 0.
REQ-030 Sub SHALL be computed by the ALU; no arithmetic duplicated outside the ALU instance.
REQ-031 Requester operand changes while not granted SHALL have no effect on held result.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force EMPTY, prio=0, op_count=0, res_out=0, res_cout=0, res_of=0, res_zf=0, res_sf=0, res_id=0.
REQ-033 While rst_n=0, req0_ready and req1_ready SHALL be 0; no transfer SHALL be counted.
REQ-034 Reset mid-operation SHALL discard any held result without asserting a consumption.

Verification
REQ-035 Single add: req0 A=5,B=-3,op=0, res_ready=1 -> res_valid next cycle, res_out=2, res_zf=0, res_sf=0, res_id=0, op_count=1.
REQ-036 Contention: both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1; results stream back-to-back with no bubble.
REQ-037 Backpressure: req1 A=7,B=7,op=1, res_ready=0 for 4 cycles -> res_out=0, res_zf=1 held, both ready=0; res_ready=1 -> next grant same cycle.
REQ-038 Overflow: A=2^63-1, B=1, op=0 -> res_out=-2^63, res_of=1, res_sf=1.
REQ-039 Reset mid-stream: rst_n=0 for one edge while FULL -> res_valid=0, op_count=0, prio=0; next grant with both valid goes to requester 0.
REQ-040 Logic ops and wrap: A=0xF0F0..., B=0xFFFF..., op=2 then op=3 -> 0xF0F0..., 0x0F0F...; CNT_W=4 run 17 transfers -> op_count=1.
